// File: rtl/count_by_2.sv
// Counter variant that steps by two; parity of Q changes only via load, clr or reset.
module count_by_2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] D,
  input  logic             up,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  output logic [WIDTH-1:0] Q
);

  counter #(
    .WIDTH(WIDTH),
    .STEP (2)
  ) u_counter (
    .clk  (clk),
    .reset(reset),
    .D    (D),
    .up   (up),
    .en   (en),
    .clr  (clr),
    .load (load),
    .Q    (Q)
  );

endmodule

// File: rtl/counter.sv
// Up/down counter with synchronous reset, clear and parallel load.
// Counts by STEP (1 or 2) modulo 2^WIDTH; Q comes straight from the state register.
module counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] D,
  input  logic             up,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  output logic [WIDTH-1:0] Q
);

  // Truncating STEP to WIDTH bits keeps the add/subtract modulo 2^WIDTH.
  localparam logic [WIDTH-1:0] StepVal = WIDTH'(STEP);

  logic [WIDTH-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      q_d = D;
    end else if (en) begin
      q_d = up ? (q_q + StepVal) : (q_q - StepVal);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    assert (!$isunknown({reset, clr, load, en}))
      else $error("counter: X/Z on a control input");
  end
`endif

endmodule

// File: tb/tb_counter.sv
// Bench for counter: directed vector table, a hand-written sequence, then random
// stimulus against a modulo-arithmetic reference model, on three configurations.
module tb_counter;

  typedef struct packed {
    logic       reset;
    logic       clr;
    logic       load;
    logic       en;
    logic       up;
    logic [9:0] d;
  } in_t;

  typedef struct {
    int          dut;
    string       name;
    in_t         in;
    int unsigned exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t in_a = '0;
  in_t in_b = '0;
  in_t in_c = '0;
  logic [0:0] q_a;
  logic [9:0] q_b;
  logic [9:0] q_c;

  int n_checks = 0;
  int n_errors = 0;
  vec_t vecs[$];

  // a: WIDTH=1 STEP=1, b: WIDTH=10 STEP=1, c: WIDTH=10 STEP=2
  counter #(.WIDTH(1), .STEP(1)) dut_a (
    .clk(clk), .reset(in_a.reset), .D(in_a.d[0:0]), .up(in_a.up),
    .en(in_a.en), .clr(in_a.clr), .load(in_a.load), .Q(q_a)
  );

  counter #(.WIDTH(10), .STEP(1)) dut_b (
    .clk(clk), .reset(in_b.reset), .D(in_b.d), .up(in_b.up),
    .en(in_b.en), .clr(in_b.clr), .load(in_b.load), .Q(q_b)
  );

  count_by_2 #(.WIDTH(10)) dut_c (
    .clk(clk), .reset(in_c.reset), .D(in_c.d), .up(in_c.up),
    .en(in_c.en), .clr(in_c.clr), .load(in_c.load), .Q(q_c)
  );

  function automatic in_t mk(logic rst, logic clr, logic ld, logic en, logic up, int unsigned d);
    in_t r;
    r.reset = rst;
    r.clr   = clr;
    r.load  = ld;
    r.en    = en;
    r.up    = up;
    r.d     = 10'(d);
    return r;
  endfunction

  // Reference: priority chain over plain integer arithmetic modulo 2^w.
  function automatic int unsigned model(int unsigned q, in_t i, int w, int step);
    int unsigned m = 1 << w;
    if (i.reset || i.clr) return 0;
    if (i.load) return int'(i.d) % m;
    if (i.en) begin
      if (i.up) return (q + step) % m;
      return (q + m - (step % m)) % m;
    end
    return q;
  endfunction

  task automatic check(string name, int unsigned act, int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned q_of(int dut);
    case (dut)
      0:       return int'(q_a);
      1:       return int'(q_b);
      default: return int'(q_c);
    endcase
  endfunction

  task automatic add(int dut, string name, in_t in, int unsigned exp);
    vec_t v;
    v.dut  = dut;
    v.name = name;
    v.in   = in;
    v.exp  = exp;
    vecs.push_back(v);
  endtask

  initial begin
    int unsigned m_a, m_b, m_c;

    // Reset all three
    in_a = mk(1, 0, 0, 0, 0, 0);
    in_b = mk(1, 0, 0, 0, 0, 0);
    in_c = mk(1, 0, 0, 0, 0, 0);
    tick();
    check("reset_a", int'(q_a), 0);
    check("reset_b", int'(q_b), 0);
    check("reset_c", int'(q_c), 0);

    // Toggle flag
    for (int k = 0; k < 4; k++) add(0, "toggle", mk(0, 0, 0, 1, k[0], 0), (k % 2 == 0) ? 1 : 0);
    add(0, "toggle_hold", mk(0, 0, 0, 0, 1, 0), 0);
    add(0, "toggle_hold2", mk(0, 0, 0, 0, 0, 0), 0);
    add(0, "toggle_down", mk(0, 0, 0, 1, 0, 0), 1);
    // Load and count down
    add(1, "load_240", mk(0, 0, 1, 0, 0, 240), 240);
    add(1, "down_239", mk(0, 0, 0, 1, 0, 0), 239);
    add(1, "down_238", mk(0, 0, 0, 1, 0, 0), 238);
    add(1, "down_237", mk(0, 0, 0, 1, 0, 0), 237);
    add(1, "load_1023", mk(0, 0, 1, 0, 0, 1023), 1023);
    add(1, "wrap_up", mk(0, 0, 0, 1, 1, 0), 0);
    // Priority with Q=5
    add(1, "load_5", mk(0, 0, 1, 0, 0, 5), 5);
    add(1, "reset_over_load", mk(1, 0, 1, 0, 0, 7), 0);
    add(1, "load_5b", mk(0, 0, 1, 0, 0, 5), 5);
    add(1, "clr_over_load", mk(0, 1, 1, 0, 0, 7), 0);
    add(1, "load_5c", mk(0, 0, 1, 0, 0, 5), 5);
    add(1, "load_over_en", mk(0, 0, 1, 1, 1, 7), 7);
    add(1, "up_ignored", mk(0, 0, 0, 0, 1, 3), 7);
    add(1, "hold_d_ignored", mk(0, 0, 0, 0, 0, 900), 7);
    // Count by 2
    add(2, "load_320", mk(0, 0, 1, 0, 0, 320), 320);
    add(2, "up2_322", mk(0, 0, 0, 1, 1, 0), 322);
    add(2, "up2_324", mk(0, 0, 0, 1, 1, 0), 324);
    add(2, "down2_322", mk(0, 0, 0, 1, 0, 0), 322);
    add(2, "load_0", mk(0, 0, 1, 0, 0, 0), 0);
    add(2, "wrap_down2", mk(0, 0, 0, 1, 0, 0), 1022);
    add(2, "load_1023", mk(0, 0, 1, 0, 0, 1023), 1023);
    add(2, "wrap_up2", mk(0, 0, 0, 1, 1, 0), 1);
    add(2, "up2_odd", mk(0, 0, 0, 1, 1, 0), 3);
    add(2, "clr2", mk(0, 1, 0, 1, 1, 0), 0);

    foreach (vecs[i]) begin
      in_a = '0;
      in_b = '0;
      in_c = '0;
      case (vecs[i].dut)
        0:       in_a = vecs[i].in;
        1:       in_b = vecs[i].in;
        default: in_c = vecs[i].in;
      endcase
      tick();
      check(vecs[i].name, q_of(vecs[i].dut), vecs[i].exp);
    end

    // Mid-sequence reset on b, then down-count across zero
    in_a = '0;
    in_c = '0;
    in_b = mk(1, 0, 0, 0, 0, 0);
    tick();
    check("mid_reset_init", int'(q_b), 0);
    for (int k = 1; k <= 3; k++) begin
      in_b = mk(0, 0, 0, 1, 1, 0);
      tick();
      check("mid_count", int'(q_b), k);
    end
    in_b = mk(1, 0, 1, 1, 1, 9);
    tick();
    check("mid_reset", int'(q_b), 0);
    in_b = mk(0, 0, 0, 1, 1, 0);
    tick();
    check("after_reset", int'(q_b), 1);
    in_b = mk(0, 0, 0, 1, 0, 0);
    tick();
    check("down_to_0", int'(q_b), 0);
    tick();
    check("wrap_down", int'(q_b), 1023);

    // Random stimulus against the model
    m_a = int'(q_a);
    m_b = int'(q_b);
    m_c = int'(q_c);
    for (int n = 0; n < 600; n++) begin
      in_t r[3];
      for (int j = 0; j < 3; j++) begin
        r[j].reset = ($urandom_range(0, 39) == 0);
        r[j].clr   = ($urandom_range(0, 29) == 0);
        r[j].load  = ($urandom_range(0, 9) == 0);
        r[j].en    = ($urandom_range(0, 3) != 0);
        r[j].up    = 1'($urandom);
        r[j].d     = 10'($urandom);
      end
      in_a = r[0];
      in_b = r[1];
      in_c = r[2];
      m_a = model(m_a, r[0], 1, 1);
      m_b = model(m_b, r[1], 10, 1);
      m_c = model(m_c, r[2], 10, 2);
      tick();
      check("rand_a", int'(q_a), m_a);
      check("rand_b", int'(q_b), m_b);
      check("rand_c", int'(q_c), m_c);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameter WIDTH, default 8, sets the bit width of D and Q; legal values are 1 or more.
REQ-002 Parameter STEP, default 1, sets the increment/decrement magnitude; legal values are 1 or 2.
REQ-003 STEP=2 is the count_by_2 configuration; a count_by_2 wrapper with the same ports and a WIDTH parameter SHALL be provided that instantiates counter with STEP=2.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port D, input, WIDTH bits: parallel load value.
REQ-007 Port up, input, 1 bit: direction; 1 = count up, 0 = count down.
REQ-008 Port en, input, 1 bit: count enable.
REQ-009 Port clr, input, 1 bit: synchronous clear to zero.
REQ-010 Port load, input, 1 bit: synchronous parallel load of D.
REQ-011 Port Q, output, WIDTH bits: registered count value.

Function
REQ-012 Q SHALL change only on a rising clk edge and SHALL be driven directly from a register, with no combinational path from inputs to Q.
REQ-013 Per-edge priority, highest first: reset, clr, load, en, hold.
  - reset=1: Q <= 0.
  - clr=1: Q <= 0.
  - load=1: Q <= D.
  - en=1 and up=1: Q <= Q + STEP.
  - en=1 and up=0: Q <= Q - STEP.
  - otherwise: Q holds.
REQ-014 Arithmetic SHALL be modulo 2^WIDTH: up-count wraps past all-ones to low values, down-count wraps past zero to high values, and no carry or borrow output is produced.
REQ-015 With WIDTH=1 and STEP=1, en=1 SHALL toggle Q on each edge regardless of up, so the block can serve as a toggle flag.
REQ-016 With STEP=2, Q SHALL keep its LSB parity across counting; only load, clr or reset may change the parity.
REQ-017 Latency SHALL be one cycle: the effect of an input sampled at edge N is visible on Q immediately after edge N.
REQ-018 Simultaneous controls SHALL resolve strictly by REQ-013; for example load=1 with en=1 loads D and does not count.
REQ-019 The up input SHALL be ignored whenever en=0.
REQ-020 Any X or Z on reset, clr, load or en SHALL be flagged by a simulation-only assertion; this assertion SHALL be excluded from synthesis.

Reset
REQ-021 reset=1 at a rising edge SHALL force Q=0 regardless of every other input, including in the middle of a count sequence.
REQ-022 No asynchronous reset path SHALL exist.
REQ-023 Power-up value before the first reset is unspecified; a user that holds reset at 0 SHALL initialise Q via load.

Verification
REQ-024 WIDTH=1, STEP=1: reset, then en=1 for 4 edges -> Q sequence 1,0,1,0; then en=0 -> Q holds.
REQ-025 WIDTH=10, STEP=1: load=1 with D=240 for one edge -> Q=240; then en=1, up=0 for 3 edges -> 239, 238, 237.
REQ-026 WIDTH=10, STEP=2: load D=320, then en=1, up=1 for 2 edges -> 322, 324; then up=0 for 1 edge -> 322.
REQ-027 Wrap, WIDTH=10:
  - STEP=1, load 1023, one up count -> Q=0.
  - STEP=2, load 0, one down count -> Q=1022.
  - STEP=2, load 1023, one up count -> Q=1.
REQ-028 Priority, with Q=5:
  - reset=1 with load=1 and D=7 -> Q=0.
  - clr=1 with load=1 -> Q=0.
  - load=1 with en=1 and D=7 -> Q=7.
REQ-029 Mid-sequence reset: count up to 3, assert reset for one edge -> Q=0; deassert with en=1, up=1 -> Q=1 on the next edge.
